// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master side issues divisions; the slave side (the divider) returns results.
// The width parameter is named bit_w because "bit" is a reserved word in SystemVerilog.
interface seq_divider_if #(
  parameter int unsigned bit_w = 5
);
  logic             start;
  logic [bit_w-1:0] I_Q;
  logic [bit_w-1:0] I_B;
  logic [bit_w-1:0] quotient;
  logic [bit_w-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, I_Q, I_B,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, I_Q, I_B,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring unsigned divider, one quotient bit per clock.
// Optional macro SEQ_DIV_ZERO_CHECK_EN: detect a zero divisor at accept time and
// finish in one cycle with div_zero=1; when undefined div_zero is tied low and a
// zero divisor runs the full iteration count.
//
// state | meaning
// IDLE  | waiting for start; results held
// DIV   | one restoring iteration per clock, p counts down to 0
// DONE  | done pulse; results valid
module seq_divider #(
  parameter int unsigned bit_w = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned P_W = $clog2(bit_w + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [bit_w:0]   a_q, a_d;
  logic [bit_w-1:0] q_q, q_d;
  logic [bit_w-1:0] b_q, b_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [bit_w-1:0] quotient_q, quotient_d;
  logic [bit_w-1:0] remainder_q, remainder_d;
  logic [bit_w:0]   shifted;
  logic [bit_w:0]   t;
`ifdef SEQ_DIV_ZERO_CHECK_EN
  logic             dz_q, dz_d;
`endif

  // State and datapath registers; reset clears everything including the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      b_q         <= b_d;
      p_q         <= p_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      dz_q        <= dz_d;
`endif
    end
  end

  // Next-state and datapath: accept in IDLE, iterate in DIV, latch results on the last iteration.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    b_d         = b_q;
    p_d         = p_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    dz_d        = dz_q;
`endif
    shifted     = {a_q[bit_w-1:0], q_q[bit_w-1]};
    t           = shifted - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.I_Q;
          b_d     = bus.I_B;
          p_d     = P_W'(bit_w);
          state_d = DIV;
`ifdef SEQ_DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
          if (bus.I_B == '0) begin
            dz_d        = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.I_Q;
            state_d     = DONE;
          end
`endif
        end
      end
      DIV: begin
        if (t[bit_w]) begin
          a_d = shifted;
          q_d = {q_q[bit_w-2:0], 1'b0};
        end else begin
          a_d = t;
          q_d = {q_q[bit_w-2:0], 1'b1};
        end
        p_d = p_q - P_W'(1);
        if (p_q == P_W'(1)) begin
          state_d     = DONE;
          quotient_d  = q_d;
          remainder_d = a_d[bit_w-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign bus.div_zero  = dz_q;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule
